// File: rtl/sb_cfg_pkg.sv
// Shared types and width helpers for the shadow-configured edge switch box.
package sb_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCommit
  } cfg_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int unsigned sel_width(input int unsigned grid_pins);
    return clog2(grid_pins + 1);
  endfunction

  function automatic int unsigned cfg_bits(input int unsigned n_mux, input int unsigned grid_pins);
    return 2 * n_mux * sel_width(grid_pins);
  endfunction

endpackage

// File: rtl/sb_cfg_loader.sv
// Handshaked serial config loader: shadow chain, bit counter and the active
// register that the routing muxes read. Shadow is copied to active in one cycle.
module sb_cfg_loader
  import sb_cfg_pkg::*;
#(
  parameter int unsigned CfgBits = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               valid_i,
  input  logic               bit_i,
  output logic               ready_o,
  output logic               done_o,
  output logic               err_o,
  output logic               tail_o,
  output logic [CfgBits-1:0] active_o
);

  localparam int unsigned CntW = clog2(CfgBits + 1);

  cfg_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CfgBits-1:0]  chain_q, chain_d;
  logic [CfgBits-1:0]  active_q, active_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chain_d  = chain_q;
    active_d = active_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLoad;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (valid_i) begin
          err_d = 1'b1;
        end
      end
      StLoad: begin
        // A restart wins over a bit presented in the same cycle.
        if (start_i) begin
          cnt_d = '0;
        end else if (valid_i) begin
          chain_d = {chain_q[CfgBits-2:0], bit_i};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(CfgBits - 1)) begin
            state_d = StCommit;
          end
        end
      end
      StCommit: begin
        active_d = chain_q;
        done_d   = 1'b1;
        if (start_i) begin
          state_d = StLoad;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          state_d = StIdle;
          if (valid_i) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      chain_q  <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chain_q  <= chain_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ready_o  = (state_q == StLoad);
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign tail_o   = chain_q[CfgBits-1];
  assign active_o = active_q;

endmodule

// File: rtl/sb_edge_shadow_cfg.sv
// Edge (left-column) switch box: fixed twist between the right X and bottom Y
// channels, with grid-pin muxes on the even low tracks driven by the active config.
module sb_edge_shadow_cfg
  import sb_cfg_pkg::*;
#(
  parameter int unsigned CHAN_WIDTH = 20,
  parameter int unsigned N_MUX      = 4,
  parameter int unsigned GRID_PINS  = 1
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [GRID_PINS-1:0]  right_grid_pins,
  input  logic [GRID_PINS-1:0]  bottom_grid_pins,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic                  cfg_bit,
  output logic                  cfg_ready,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic                  ccff_tail
);

  localparam int unsigned SEL_W    = sel_width(GRID_PINS);
  localparam int unsigned CFG_BITS = cfg_bits(N_MUX, GRID_PINS);

  logic [CFG_BITS-1:0] active;

  sb_cfg_loader #(
    .CfgBits(CFG_BITS)
  ) u_loader (
    .clk_i   (prog_clk),
    .rst_i   (pReset),
    .start_i (cfg_start),
    .valid_i (cfg_valid),
    .bit_i   (cfg_bit),
    .ready_o (cfg_ready),
    .done_o  (cfg_done),
    .err_o   (cfg_err),
    .tail_o  (ccff_tail),
    .active_o(active)
  );

  // Select 0 keeps the twisted track; out-of-range selects drive 0.
  function automatic logic pick(input logic [SEL_W-1:0] sel, input logic track,
                                input logic [GRID_PINS-1:0] pins);
    logic res;
    res = (sel == '0) ? track : 1'b0;
    for (int unsigned p = 0; p < GRID_PINS; p++) begin
      if (sel == SEL_W'(p + 1)) res = pins[p];
    end
    return res;
  endfunction

  for (genvar m = 0; m < CHAN_WIDTH - 1; m++) begin : g_track
    if ((m % 2 == 0) && (m / 2 < N_MUX)) begin : g_mux
      localparam int unsigned MuxIdx = m / 2;
      assign chanx_right_out[m]  = pick(active[MuxIdx*SEL_W +: SEL_W],
                                        chany_bottom_in[CHAN_WIDTH-2-m], right_grid_pins);
      assign chany_bottom_out[m] = pick(active[(N_MUX+MuxIdx)*SEL_W +: SEL_W],
                                        chanx_right_in[CHAN_WIDTH-2-m], bottom_grid_pins);
    end else begin : g_pass
      assign chanx_right_out[m]  = chany_bottom_in[CHAN_WIDTH-2-m];
      assign chany_bottom_out[m] = chanx_right_in[CHAN_WIDTH-2-m];
    end
  end

  assign chanx_right_out[CHAN_WIDTH-1]  = chany_bottom_in[CHAN_WIDTH-1];
  assign chany_bottom_out[CHAN_WIDTH-1] = chanx_right_in[CHAN_WIDTH-1];

endmodule

// File: tb/tb_sb_edge_shadow_cfg.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sb_edge_shadow_cfg;

  localparam int CW = 20;
  localparam int NM = 4;
  localparam int NB = 8;

  logic          prog_clk = 1'b0;
  logic          pReset = 1'b1;
  logic [CW-1:0] chanx_right_in = '0;
  logic [CW-1:0] chany_bottom_in = '0;
  logic [0:0]    right_grid_pins = '0;
  logic [0:0]    bottom_grid_pins = '0;
  logic [CW-1:0] chanx_right_out;
  logic [CW-1:0] chany_bottom_out;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_bit = 1'b0;
  logic          cfg_ready, cfg_done, cfg_err, ccff_tail;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  sb_edge_shadow_cfg #(
    .CHAN_WIDTH(CW),
    .N_MUX     (NM),
    .GRID_PINS (1)
  ) dut (
    .prog_clk        (prog_clk),
    .pReset          (pReset),
    .chanx_right_in  (chanx_right_in),
    .chany_bottom_in (chany_bottom_in),
    .right_grid_pins (right_grid_pins),
    .bottom_grid_pins(bottom_grid_pins),
    .chanx_right_out (chanx_right_out),
    .chany_bottom_out(chany_bottom_out),
    .cfg_start       (cfg_start),
    .cfg_valid       (cfg_valid),
    .cfg_bit         (cfg_bit),
    .cfg_ready       (cfg_ready),
    .cfg_done        (cfg_done),
    .cfg_err         (cfg_err),
    .ccff_tail       (ccff_tail)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          hist[$];      // accepted bits, newest at back
  bit          m_loading;
  int          m_count;
  bit          m_commit_due;
  logic [NB-1:0] m_active;
  bit          m_done;
  bit          m_err;

  function automatic logic [NB-1:0] shadow_val();
    logic [NB-1:0] v;
    v = '0;
    for (int k = 0; k < NB; k++) if (hist.size() > k) v[k] = hist[hist.size()-1-k];
    return v;
  endfunction

  // Twist every track to the opposite channel; even low tracks may take the grid pin.
  function automatic logic [CW-1:0] exp_route(input logic [CW-1:0] opp, input logic pin,
                                              input logic [NM-1:0] sels);
    logic [CW-1:0] r;
    for (int m = 0; m < CW - 1; m++) r[m] = opp[CW-2-m];
    r[CW-1] = opp[CW-1];
    for (int j = 0; j < NM; j++) if (sels[j]) r[2*j] = pin;
    return r;
  endfunction

  always @(posedge prog_clk) begin
    if (pReset) begin
      hist.delete();
      m_loading = 0; m_count = 0; m_commit_due = 0;
      m_active = '0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      if (m_commit_due) begin
        m_active = shadow_val();
        m_done = 1;
        m_commit_due = 0;
        if (cfg_start) begin
          m_loading = 1; m_count = 0; m_err = 0;
        end else if (cfg_valid) m_err = 1;
      end else if (m_loading) begin
        if (cfg_start) m_count = 0;
        else if (cfg_valid) begin
          hist.push_back(cfg_bit);
          if (hist.size() > NB) void'(hist.pop_front());
          m_count++;
          if (m_count == NB) begin
            m_loading = 0;
            m_commit_due = 1;
          end
        end
      end else begin
        if (cfg_start) begin
          m_loading = 1; m_count = 0; m_err = 0;
        end else if (cfg_valid) m_err = 1;
      end
    end
  end

  always @(negedge prog_clk) begin
    if (cmp_en) begin
      chk("chanx_right_out", 32'(chanx_right_out),
          32'(exp_route(chany_bottom_in, right_grid_pins[0], m_active[NM-1:0])));
      chk("chany_bottom_out", 32'(chany_bottom_out),
          32'(exp_route(chanx_right_in, bottom_grid_pins[0], m_active[NB-1:NM])));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_loading));
      chk("cfg_done", 32'(cfg_done), 32'(m_done));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("ccff_tail", 32'(ccff_tail), 32'(shadow_val()[NB-1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic s, input logic v, input logic b);
    cfg_start = s;
    cfg_valid = v;
    cfg_bit   = b;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] val);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = NB - 1; i >= 0; i--) cyc(1'b0, 1'b1, val[i]);
  endtask

  int   dones;
  logic tail_before;

  initial begin
    cyc(1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    pReset = 1'b0;

    // Reset state and plain twist
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_tail", 32'(ccff_tail), 32'd0);
    chanx_right_in = 20'h00001;
    #1 chk("twist_x_to_y18", 32'(chany_bottom_out[18]), 32'd1);
    chany_bottom_in = 20'h40000;
    #1 chk("twist_y18_to_x0", 32'(chanx_right_out[0]), 32'd1);

    // 8'b1000_0000: only bottom mux 3 picks its grid pin
    chanx_right_in = '0; chany_bottom_in = '0;
    bottom_grid_pins = 1'b1; right_grid_pins = 1'b1;
    load_byte(8'h80);
    chk("ready_after_8th", 32'(cfg_ready), 32'd0);
    chk("no_done_yet", 32'(cfg_done), 32'd0);
    chk("bottom6_still_track", 32'(chany_bottom_out[6]), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_pulse_80", 32'(cfg_done), 32'd1);
    chk("bottom6_pin", 32'(chany_bottom_out[6]), 32'd1);
    chk("bottom4_track", 32'(chany_bottom_out[4]), 32'd0);
    chk("right0_track", 32'(chanx_right_out[0]), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("done_one_cycle", 32'(cfg_done), 32'd0);

    // 8'hFF with a stall mid-load
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk("stall_routing_held", 32'(chanx_right_out[6:0]), 32'h00);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("ff_right_pins", 32'({chanx_right_out[6], chanx_right_out[4],
                              chanx_right_out[2], chanx_right_out[0]}), 32'hF);

    // Restart after 5 bits, then 8'h5A
    dones = 0;
    right_grid_pins = 1'b1; chany_bottom_in = '0;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      dones += int'(cfg_done);
    end
    load_byte(8'h5A);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      dones += int'(cfg_done);
    end
    chk("restart_one_done", 32'(dones), 32'd1);
    chk("restart_right_sel", 32'({chanx_right_out[6], chanx_right_out[4],
                                  chanx_right_out[2], chanx_right_out[0]}), 32'hA);

    // Valid while idle is an error; start clears it
    tail_before = ccff_tail;
    cyc(1'b0, 1'b1, ~ccff_tail);
    chk("idle_valid_err", 32'(cfg_err), 32'd1);
    chk("idle_chain_kept", 32'(ccff_tail), 32'(tail_before));
    cyc(1'b1, 1'b0, 1'b0);
    chk("start_clears_err", 32'(cfg_err), 32'd0);

    // Reset mid-load
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
    pReset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    pReset = 1'b0;
    chk("rst_mid_ready", 32'(cfg_ready), 32'd0);
    chk("rst_mid_active", 32'({chanx_right_out[6], chanx_right_out[4],
                               chanx_right_out[2], chanx_right_out[0]}), 32'h0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      dones += int'(cfg_done);
    end
    chk("rst_mid_no_done", 32'(dones), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      chanx_right_in   = CW'($urandom);
      chany_bottom_in  = CW'($urandom);
      right_grid_pins  = 1'($urandom);
      bottom_grid_pins = 1'($urandom);
      pReset           = ($urandom_range(0, 299) == 0);
      cyc(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
    end
    pReset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    @(negedge prog_clk);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
